// File: rtl/plasma_pkg.sv
// plasma_pkg: shared state encoding and accumulator geometry for the plasma phase generator
package plasma_pkg;

    localparam int ACC_W_DEF  = 16;
    localparam int FRAC_W_DEF = 6;
    localparam int PHASE_W    = 10;
    localparam int STEP_W     = 8;

    typedef enum logic [1:0] {
        WAIT_VB = 2'd0,
        VBLANK  = 2'd1,
        HBLANK  = 2'd2,
        ACTIVE  = 2'd3
    } state_e;

endpackage

// File: rtl/plasma_phase_gen.sv
// plasma_phase_gen: raster-synchronous phase accumulator feeding a 10-bit cosine lookup
module plasma_phase_gen
    import plasma_pkg::*;
#(
    parameter int ACC_W  = ACC_W_DEF,
    parameter int FRAC_W = FRAC_W_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                ce_pix,
    input  logic                en,
    input  logic                hblank,
    input  logic                vblank,
    input  logic [STEP_W-1:0]   h_step,
    input  logic [STEP_W-1:0]   v_step,
    input  logic [STEP_W-1:0]   f_step,
    output logic [PHASE_W-1:0]  phase,
    output logic                phase_valid,
    output logic [7:0]          frame_cnt
);

    state_e              state_q, state_d;
    logic [ACC_W-1:0]    frame_acc_q, frame_acc_d;
    logic [ACC_W-1:0]    line_acc_q, line_acc_d;
    logic [ACC_W-1:0]    pix_acc_q, pix_acc_d;
    logic [STEP_W-1:0]   h_step_q, h_step_d;
    logic [STEP_W-1:0]   v_step_q, v_step_d;
    logic [PHASE_W-1:0]  phase_q, phase_d;
    logic                phase_valid_q, phase_valid_d;
    logic [7:0]          frame_cnt_q, frame_cnt_d;
    logic                vb_enter;
    logic [ACC_W-1:0]    frame_sum;

    // f_step is consumed on the same edge it is latched, so the live input feeds the frame sum
    assign frame_sum = frame_acc_q + ACC_W'(f_step);

    // Next-state and datapath: en drops to WAIT_VB unconditionally, everything else waits for ce_pix
    always_comb begin
        state_d       = state_q;
        frame_acc_d   = frame_acc_q;
        line_acc_d    = line_acc_q;
        pix_acc_d     = pix_acc_q;
        h_step_d      = h_step_q;
        v_step_d      = v_step_q;
        phase_d       = phase_q;
        phase_valid_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        vb_enter      = 1'b0;
        if (!en) begin
            state_d = WAIT_VB;
        end else if (ce_pix) begin
            case (state_q)
                WAIT_VB: vb_enter = vblank;
                VBLANK:  state_d = vblank ? VBLANK : HBLANK;
                HBLANK: begin
                    vb_enter = vblank;
                    if (!vblank && !hblank) begin
                        state_d   = ACTIVE;
                        pix_acc_d = line_acc_q;
                    end
                end
                ACTIVE: begin
                    vb_enter = vblank;
                    if (!vblank && hblank) begin
                        state_d    = HBLANK;
                        line_acc_d = line_acc_q + ACC_W'(v_step_q);
                    end else if (!vblank) begin
                        phase_d       = PHASE_W'(pix_acc_q >> FRAC_W);
                        phase_valid_d = 1'b1;
                        pix_acc_d     = pix_acc_q + ACC_W'(h_step_q);
                    end
                end
                default: state_d = WAIT_VB;
            endcase
            if (vb_enter) begin
                state_d     = VBLANK;
                h_step_d    = h_step;
                v_step_d    = v_step;
                frame_acc_d = frame_sum;
                line_acc_d  = frame_sum;
                frame_cnt_d = frame_cnt_q + 8'd1;
            end
        end
    end

    // State and datapath registers with synchronous reset overriding every other input
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_VB;
            frame_acc_q   <= '0;
            line_acc_q    <= '0;
            pix_acc_q     <= '0;
            h_step_q      <= '0;
            v_step_q      <= '0;
            phase_q       <= '0;
            phase_valid_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            frame_acc_q   <= frame_acc_d;
            line_acc_q    <= line_acc_d;
            pix_acc_q     <= pix_acc_d;
            h_step_q      <= h_step_d;
            v_step_q      <= v_step_d;
            phase_q       <= phase_d;
            phase_valid_q <= phase_valid_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign phase       = phase_q;
    assign phase_valid = phase_valid_q;
    assign frame_cnt   = frame_cnt_q;

endmodule

// File: doc/plasma_phase_gen.md
PLASMA_PHASE_GEN -- requirements
Module: plasma_phase_gen

Interface
REQ-001 SHALL have parameter ACC_W, default 16, accumulator width (integer phase bits plus fraction).
REQ-002 SHALL have parameter FRAC_W, default 6, fractional bits; phase = acc[ACC_W-1:FRAC_W], fixed at 10 bits.
REQ-003 SHALL have port clk  input  1  single system clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port ce_pix  input  1  pixel clock enable; state advances only on cycles with ce_pix=1.
REQ-006 SHALL have port en  input  1  generator enable.
REQ-007 SHALL have port hblank  input  1  horizontal blanking.
REQ-008 SHALL have port vblank  input  1  vertical blanking.
REQ-009 SHALL have port h_step  input  8  per-pixel phase increment, unsigned, FRAC_W fraction bits.
REQ-010 SHALL have port v_step  input  8  per-line phase increment, same format.
REQ-011 SHALL have port f_step  input  8  per-frame phase increment, same format.
REQ-012 SHALL have port phase  output  10  phase word for the downstream 10-bit cosine lookup.
REQ-013 SHALL have port phase_valid  output  1  phase carries a visible pixel this cycle.
REQ-014 SHALL have port frame_cnt  output  8  frames started since reset, wraps 255->0.

Function
REQ-015 SHALL hold internal accumulators frame_acc, line_acc and pix_acc, each ACC_W bits, all additions modulo 2^ACC_W.
REQ-016 SHALL implement states WAIT_VB, VBLANK, HBLANK, ACTIVE; all transitions occur only on ce_pix=1 cycles, except the en rule of REQ-024.
REQ-017 WAIT_VB -> VBLANK when vblank=1 and en=1; WAIT_VB never produces output.
REQ-018 On entry to VBLANK: latch h_step, v_step and f_step; frame_acc += f_step; line_acc <= new frame_acc; frame_cnt += 1.
REQ-019 VBLANK -> HBLANK when vblank=0; HBLANK -> ACTIVE when hblank=0 and vblank=0, loading pix_acc <= line_acc.
REQ-020 In ACTIVE, on each ce_pix with hblank=0: phase <= pix_acc[ACC_W-1:FRAC_W]; phase_valid <= 1; pix_acc += latched h_step.
REQ-021 ACTIVE -> HBLANK when hblank=1; on that transition, line_acc += latched v_step.
REQ-022 vblank=1 in HBLANK or ACTIVE SHALL go to VBLANK and takes priority over hblank; frame_cnt increments once per VBLANK entry, not per cycle.
REQ-023 phase_valid SHALL be 1 exactly one clk after each qualifying ce_pix of REQ-020 and 0 otherwise; phase holds its last value when phase_valid=0; latency from ce_pix to phase is 1 clk.
REQ-024 en=0 in any state SHALL force WAIT_VB on the next clk regardless of ce_pix, with phase_valid=0 and accumulators and frame_cnt held.
REQ-025 Step inputs changed mid-frame SHALL have no effect until the next VBLANK entry.
REQ-026 Phase wrap 1023->0 SHALL occur by natural modulo arithmetic with no saturation.

Reset
REQ-027 reset=1 SHALL set state=WAIT_VB, all accumulators=0, latched steps=0, phase=0, phase_valid=0, frame_cnt=0, overriding all other inputs including ce_pix.
REQ-028 Reset asserted mid-line SHALL drop phase_valid to 0 on the next clk; no output until a full vblank entry follows reset release.

Structure
REQ-029 The state enum, ACC_W and FRAC_W defaults SHALL live in shared package plasma_pkg.
REQ-030 SHALL be a single module with no sub-modules; the parent instantiates the cosine lookup on phase.

Verification
REQ-031 Reset: reset=1 for 2 clks -> phase=0, phase_valid=0, frame_cnt=0; 10 ACTIVE pixels before any vblank -> phase_valid stays 0.
REQ-032 f_step=0x40, h_step=0x40, v_step=0, one vblank then line of 4 pixels -> phase 1,2,3,4 with valid, frame_cnt=1.
REQ-033 f_step=0, h_step=0, v_step=0x80 -> line 0 phase 0, line 1 phase 2, line 2 phase 4, constant within each line.
REQ-034 f_step=0, h_step=0x80, 513-pixel line -> pixel 511 phase 1022, pixel 512 phase 0 (wrap).
REQ-035 hblank=1 and vblank=1 together for 3 ce_pix -> single VBLANK entry, frame_cnt +1, no valid output.
REQ-036 en=0 mid-line -> phase_valid=0 next clk, accumulators unchanged; en=1 mid-frame -> no valid until next vblank, then output restarts from frame_acc+f_step.
